caesar_bcd_stepper: RTL and testbench
=====================================

CAESAR_BCD_STEPPER -- requirements
Module: caesar_bcd_stepper

Interface
REQ-001 SHALL have parameter ALPHA_SIZE, default 26, alphabet modulus; legal range 2..99.
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000, CLOCK_50 cycles per step tick; legal range >=2.
REQ-003 SHALL have port CLOCK_50  in  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  in  1  step enable, sampled only on tick cycles.
REQ-006 SHALL have port dir  in  1  step direction: 0 = up (+1), 1 = down (-1).
REQ-007 SHALL have port key_load  in  1  single-cycle request to load key_in.
REQ-008 SHALL have port key_in  in  7  unsigned shift key, binary.
REQ-009 SHALL have port key_ack  out  1  one-cycle pulse: key accepted.
REQ-010 SHALL have port key_err  out  1  one-cycle pulse: key rejected, key_in >= ALPHA_SIZE.
REQ-011 SHALL have port plain_bcd  out  8  plaintext index, two BCD digits: [7:4] tens, [3:0] units.
REQ-012 SHALL have port cipher_bcd  out  8  ciphertext index (plain + key) mod ALPHA_SIZE, two BCD digits.
REQ-013 SHALL have port step  out  1  one-cycle pulse: plaintext index changed this cycle.
REQ-014 SHALL have port wrap  out  1  one-cycle pulse coincident with step when the index wrapped.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick for one cycle at terminal count, free-running whether or not en is high.
REQ-016 On tick with en=1, dir=0: plain SHALL go to plain+1, or to 0 from ALPHA_SIZE-1 with wrap=1.
REQ-017 On tick with en=1, dir=1: plain SHALL go to plain-1, or to ALPHA_SIZE-1 from 0 with wrap=1.
REQ-018 plain_bcd SHALL be kept as a BCD pair directly: units 9->0 carries into tens; down-count 0->9 borrows; no binary-to-BCD division on this path.
REQ-019 On tick with en=0, plain, step and wrap SHALL hold/remain 0.
REQ-020 key_load with key_in < ALPHA_SIZE SHALL register the key and pulse key_ack in the following cycle; otherwise key unchanged and key_err pulses in the following cycle.
REQ-021 key_load coinciding with tick SHALL be accepted; that step SHALL use the old key, and the new key SHALL apply from the next cycle.
REQ-022 cipher index SHALL be computed as plain + key with one conditional subtract of ALPHA_SIZE (8-bit intermediate, no overflow), converted to BCD and registered.
REQ-023 cipher_bcd SHALL lag any change of plain or key by exactly one cycle.
REQ-024 key_ack, key_err, step and wrap SHALL never be high longer than one cycle per event.

Reset
REQ-025 While rst=0: prescaler=0, plain=0, key=0, plain_bcd=8'h00, cipher_bcd=8'h00, key_ack=key_err=step=wrap=0.
REQ-026 Reset asserted mid-tick or mid-key-load SHALL abort the operation with no pulse emitted after release.
REQ-027 After rst release, the first tick SHALL occur exactly TICK_DIV cycles later.

Structure
REQ-028 Shared package caesar_pkg SHALL hold ALPHA_DEFAULT=26, TICK_DIV_DEFAULT=50_000_000, the 4-bit BCD digit type and the 2-digit BCD pair type.
REQ-029 Prescaler SHALL be a separate sub-module caesar_tick_gen (parameter TICK_DIV; ports CLOCK_50, rst, tick).
REQ-030 Output decoding to 7-segment SHALL remain outside this block in the existing bcd7seg decoder.

Verification
REQ-031 TICK_DIV=4, en=1, dir=0, 30 ticks -> plain_bcd 00,01..25,00..04; wrap pulses once, at 25->00.
REQ-032 TICK_DIV=4, dir=1 from reset -> first step plain_bcd=8'h25 with wrap=1, then 24, 23.
REQ-033 Load key 3 at plain=24 -> key_ack next cycle; cipher_bcd=8'h01 one cycle later; after step plain=25 -> cipher=8'h02.
REQ-034 key_in=26 -> key_err one cycle later; key and cipher_bcd unchanged.
REQ-035 key_load on the tick cycle with key 5 (old key 0), plain 08->09 -> cipher 09 for one cycle, then 8'h14.
REQ-036 ALPHA_SIZE=60, TICK_DIV=2, rst pulsed at plain=47 -> all outputs 0 immediately; next step exactly 2 cycles after release, plain=01.

Source files
------------

// File: rtl/caesar_pkg.sv
// Shared definitions for the Caesar BCD stepper.
//   ALPHA_DEFAULT / TICK_DIV_DEFAULT : default parameter values
//   bcd_digit_t / bcd_pair_t         : one BCD digit and a tens/units pair
//   bcd_to_bin / bin_to_bcd          : conversions for indices below 100
package caesar_pkg;

  localparam int unsigned ALPHA_DEFAULT    = 26;
  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_pair_t;

  // tens * 10 + units; the multiply is by a constant so it reduces to shifts and adds.
  function automatic logic [6:0] bcd_to_bin(bcd_pair_t p);
    return 7'(p.tens) * 7'd10 + 7'(p.units);
  endfunction

  // Only valid for v < 100.
  function automatic bcd_pair_t bin_to_bcd(logic [7:0] v);
    bcd_pair_t r;
    r.tens  = 4'(v / 8'd10);
    r.units = 4'(v % 8'd10);
    return r;
  endfunction

endpackage

// File: rtl/caesar_tick_gen.sv
// Free-running prescaler producing a one-cycle step tick.
//   CLOCK_50 : system clock
//   rst      : asynchronous active-low reset
//   tick     : high for one cycle when the counter is at TICK_DIV-1
module caesar_tick_gen
  import caesar_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tick = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/caesar_bcd_stepper.sv
// Modulo-ALPHA_SIZE plaintext index stepper with a Caesar-shifted ciphertext index.
//   CLOCK_50, rst       : clock, asynchronous active-low reset
//   en, dir             : step enable and direction (0 up, 1 down), sampled on ticks
//   key_load, key_in    : key load request and key value
//   key_ack, key_err    : one-cycle accept / reject pulses
//   plain_bcd           : plaintext index as two BCD digits
//   cipher_bcd          : (plain + key) mod ALPHA_SIZE as two BCD digits, one cycle behind
//   step, wrap          : one-cycle pulses for index change and wrap-around
module caesar_bcd_stepper
  import caesar_pkg::*;
#(
  parameter int unsigned ALPHA_SIZE = ALPHA_DEFAULT,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       key_load,
  input  logic [6:0] key_in,
  output logic       key_ack,
  output logic       key_err,
  output logic [7:0] plain_bcd,
  output logic [7:0] cipher_bcd,
  output logic       step,
  output logic       wrap
);

  localparam logic [6:0] AlphaW   = 7'(ALPHA_SIZE);
  localparam bcd_pair_t  AlphaMax = bin_to_bcd(8'(ALPHA_SIZE - 1));

  logic tick;

  caesar_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50(CLOCK_50),
    .rst     (rst),
    .tick    (tick)
  );

  bcd_pair_t  plain_d, plain_q;
  bcd_pair_t  cipher_d, cipher_q;
  logic [6:0] key_d, key_q;
  logic [6:0] pend_key_d, pend_key_q;
  logic       pend_d, pend_q;
  logic       step_d, step_q;
  logic       wrap_d, wrap_q;
  logic       ack_d, ack_q;
  logic       err_d, err_q;
  logic [7:0] sum;

  // Plaintext index kept directly in BCD: carry/borrow between digits, no division.
  always_comb begin
    plain_d = plain_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (tick && en) begin
      step_d = 1'b1;
      if (!dir) begin
        if (plain_q == AlphaMax) begin
          plain_d = '0;
          wrap_d  = 1'b1;
        end else if (plain_q.units == 4'd9) begin
          plain_d.units = 4'd0;
          plain_d.tens  = plain_q.tens + 4'd1;
        end else begin
          plain_d.units = plain_q.units + 4'd1;
        end
      end else begin
        if (plain_q == '0) begin
          plain_d = AlphaMax;
          wrap_d  = 1'b1;
        end else if (plain_q.units == 4'd0) begin
          plain_d.units = 4'd9;
          plain_d.tens  = plain_q.tens - 4'd1;
        end else begin
          plain_d.units = plain_q.units - 4'd1;
        end
      end
    end
  end

  // A key accepted on a tick cycle is parked for one cycle so the cipher
  // for that step is still formed with the old key.
  always_comb begin
    key_d      = key_q;
    pend_d     = 1'b0;
    pend_key_d = pend_key_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    if (pend_q) begin
      key_d = pend_key_q;
    end
    if (key_load) begin
      if (key_in < AlphaW) begin
        ack_d = 1'b1;
        if (tick) begin
          pend_d     = 1'b1;
          pend_key_d = key_in;
        end else begin
          key_d = key_in;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Both operands are below ALPHA_SIZE, so one conditional subtract is enough.
  always_comb begin
    sum = {1'b0, bcd_to_bin(plain_q)} + {1'b0, key_q};
    if (sum >= {1'b0, AlphaW}) begin
      sum = sum - {1'b0, AlphaW};
    end
    cipher_d = bin_to_bcd(sum);
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      plain_q    <= '0;
      cipher_q   <= '0;
      key_q      <= '0;
      pend_key_q <= '0;
      pend_q     <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      plain_q    <= plain_d;
      cipher_q   <= cipher_d;
      key_q      <= key_d;
      pend_key_q <= pend_key_d;
      pend_q     <= pend_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign plain_bcd  = plain_q;
  assign cipher_bcd = cipher_q;
  assign step       = step_q;
  assign wrap       = wrap_q;
  assign key_ack    = ack_q;
  assign key_err    = err_q;

endmodule

// File: tb/tb_caesar_bcd_stepper.sv
// Bench for caesar_bcd_stepper: two instances (26/4 and 60/2) share stimulus and are
// compared every cycle against an integer reference model, plus directed checks.
module tb_caesar_bcd_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       key_load;
  logic [6:0] key_in;

  logic [1:0]      key_ack, key_err, step, wrap;
  logic [1:0][7:0] plain_bcd, cipher_bcd;

  always #5 clk = ~clk;

  caesar_bcd_stepper #(
    .ALPHA_SIZE(26),
    .TICK_DIV  (4)
  ) u_dut_a26 (
    .CLOCK_50  (clk),
    .rst       (rst),
    .en        (en),
    .dir       (dir),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ack   (key_ack[0]),
    .key_err   (key_err[0]),
    .plain_bcd (plain_bcd[0]),
    .cipher_bcd(cipher_bcd[0]),
    .step      (step[0]),
    .wrap      (wrap[0])
  );

  caesar_bcd_stepper #(
    .ALPHA_SIZE(60),
    .TICK_DIV  (2)
  ) u_dut_a60 (
    .CLOCK_50  (clk),
    .rst       (rst),
    .en        (en),
    .dir       (dir),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ack   (key_ack[1]),
    .key_err   (key_err[1]),
    .plain_bcd (plain_bcd[1]),
    .cipher_bcd(cipher_bcd[1]),
    .step      (step[1]),
    .wrap      (wrap[1])
  );

  int alpha[2]    = '{26, 60};
  int tick_div[2] = '{4, 2};

  // Reference model: indices as plain integers.
  int m_plain[2], m_key[2], m_cipher[2], m_pend_key[2], m_n[2];
  bit m_pend[2], m_step[2], m_wrap[2], m_ack[2], m_err[2];

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] to_bcd(int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string when);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s[%0d] plain", when, i), plain_bcd[i], to_bcd(m_plain[i]));
      chk($sformatf("%s[%0d] cipher", when, i), cipher_bcd[i], to_bcd(m_cipher[i]));
      chk($sformatf("%s[%0d] step", when, i), {7'd0, step[i]}, {7'd0, m_step[i]});
      chk($sformatf("%s[%0d] wrap", when, i), {7'd0, wrap[i]}, {7'd0, m_wrap[i]});
      chk($sformatf("%s[%0d] ack", when, i), {7'd0, key_ack[i]}, {7'd0, m_ack[i]});
      chk($sformatf("%s[%0d] err", when, i), {7'd0, key_err[i]}, {7'd0, m_err[i]});
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 2; i++) begin
      m_plain[i] = 0; m_key[i] = 0; m_cipher[i] = 0; m_pend_key[i] = 0; m_n[i] = 0;
      m_pend[i] = 0; m_step[i] = 0; m_wrap[i] = 0; m_ack[i] = 0; m_err[i] = 0;
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit tick;
      bit mv;
      int next_key;
      tick = (m_n[i] % tick_div[i]) == tick_div[i] - 1;
      m_n[i]++;
      mv = tick && en;
      m_cipher[i] = (m_plain[i] + m_key[i]) % alpha[i];
      m_step[i] = mv;
      m_wrap[i] = mv && (dir ? (m_plain[i] == 0) : (m_plain[i] == alpha[i] - 1));
      if (mv) m_plain[i] = (m_plain[i] + (dir ? alpha[i] - 1 : 1)) % alpha[i];
      next_key = m_pend[i] ? m_pend_key[i] : m_key[i];
      m_pend[i] = 0;
      m_ack[i] = 0;
      m_err[i] = 0;
      if (key_load) begin
        if (int'(key_in) < alpha[i]) begin
          m_ack[i] = 1;
          // A key arriving with a tick takes effect one cycle later.
          if (tick) begin
            m_pend[i] = 1;
            m_pend_key[i] = int'(key_in);
          end else begin
            next_key = int'(key_in);
          end
        end else begin
          m_err[i] = 1;
        end
      end
      m_key[i] = next_key;
    end
    #1;
    check_all("cyc");
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_zero();
    check_all("rst");
    key_load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; dir = 1'b0; key_load = 1'b1; key_in = 7'd3;
    model_zero();
    apply_reset();

    // Up-count 30 ticks on the 26/4 instance: ends at 04 after one wrap.
    begin
      int wraps = 0;
      for (int c = 0; c < 120; c++) begin
        cycle();
        if (wrap[0]) wraps++;
      end
      chk("up30 plain", plain_bcd[0], 8'h04);
      chk("up30 wraps", 8'(wraps), 8'd1);
    end

    // Down-count from reset: 25 with wrap, then 24, 23.
    dir = 1'b1;
    apply_reset();
    repeat (4) cycle();
    chk("down first plain", plain_bcd[0], 8'h25);
    chk("down first wrap", {7'd0, wrap[0]}, 8'd1);
    repeat (4) cycle();
    chk("down second plain", plain_bcd[0], 8'h24);
    repeat (4) cycle();
    chk("down third plain", plain_bcd[0], 8'h23);

    // Key 3 loaded at plain 24.
    dir = 1'b0;
    apply_reset();
    repeat (96) cycle();
    chk("pre-load plain", plain_bcd[0], 8'h24);
    en = 1'b0; key_load = 1'b1; key_in = 7'd3;
    cycle();
    key_load = 1'b0;
    chk("load3 ack", {7'd0, key_ack[0]}, 8'd1);
    cycle();
    chk("load3 ack gone", {7'd0, key_ack[0]}, 8'd0);
    chk("load3 cipher", cipher_bcd[0], 8'h01);
    en = 1'b1;
    repeat (2) cycle();
    en = 1'b0;
    chk("load3 step plain", plain_bcd[0], 8'h25);
    cycle();
    chk("load3 step cipher", cipher_bcd[0], 8'h02);

    // Out-of-range key on the 26 instance.
    key_load = 1'b1; key_in = 7'd26;
    cycle();
    key_load = 1'b0;
    chk("key26 err", {7'd0, key_err[0]}, 8'd1);
    chk("key26 no ack", {7'd0, key_ack[0]}, 8'd0);
    cycle();
    chk("key26 cipher", cipher_bcd[0], 8'h02);

    // Key load on a tick cycle: plain 08 -> 09, key 0 -> 5.
    en = 1'b1;
    apply_reset();
    repeat (32) cycle();
    chk("pre-tickload plain", plain_bcd[0], 8'h08);
    repeat (3) cycle();
    key_load = 1'b1; key_in = 7'd5;
    cycle();
    key_load = 1'b0; en = 1'b0;
    chk("tickload plain", plain_bcd[0], 8'h09);
    chk("tickload ack", {7'd0, key_ack[0]}, 8'd1);
    cycle();
    chk("tickload cipher old key", cipher_bcd[0], 8'h09);
    cycle();
    chk("tickload cipher new key", cipher_bcd[0], 8'h14);

    // 60/2 instance: reset at plain 47, then first step two cycles after release.
    en = 1'b1;
    apply_reset();
    repeat (94) cycle();
    chk("a60 pre-reset plain", plain_bcd[1], 8'h47);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_zero();
    chk("a60 reset plain", plain_bcd[1], 8'h00);
    chk("a60 reset cipher", cipher_bcd[1], 8'h00);
    check_all("midrst");
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("a60 no step c1", {7'd0, step[1]}, 8'd0);
    cycle();
    chk("a60 step c2", {7'd0, step[1]}, 8'd1);
    chk("a60 plain c2", plain_bcd[1], 8'h01);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      key_load = ($urandom_range(0, 4) == 0);
      key_in   = 7'($urandom_range(0, 70));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
